// File: rtl/pulse_req_scheduler_if.sv
// pulse_req_scheduler_if
//   Grant handshake between the scheduler and the shared service resource.
//   Signals:
//     svc_valid  - grant valid (scheduler -> resource)
//     svc_ready  - resource accepts the current grant (resource -> scheduler)
//     svc_id     - index of the granted channel, stable while svc_valid=1
//     svc_onehot - one-hot form of svc_id while svc_valid=1, else 0
//   Modports: master (scheduler side), slave (resource side).
interface pulse_req_scheduler_if #(
  parameter int N = 4
) ();
  localparam int IDW = $clog2(N);

  logic           svc_valid;
  logic           svc_ready;
  logic [IDW-1:0] svc_id;
  logic [N-1:0]   svc_onehot;

  modport master (
    output svc_valid,
    output svc_id,
    output svc_onehot,
    input  svc_ready
  );

  modport slave (
    input  svc_valid,
    input  svc_id,
    input  svc_onehot,
    output svc_ready
  );
endinterface

// File: rtl/pulse_req_scheduler.sv
// pulse_req_scheduler
//   Multi-channel event scheduler for one shared service resource. Each
//   level request line is rising-edge detected; every edge becomes a sticky
//   pending event. A round-robin arbiter hands pending events out one at a
//   time over a valid/ready grant handshake.
//
//   Ports:
//     clk        - rising-edge clock
//     rst        - synchronous active-high reset
//     req_in     - N level request lines, already synchronous to clk
//     svc        - grant handshake (pulse_req_scheduler_if.master):
//                  svc_valid / svc_ready / svc_id / svc_onehot
//     pend_out   - current pending-event vector
//     busy       - high while a grant is outstanding
//     drop_pulse - one-cycle flag per channel: an edge hit an already
//                  pending (and not just completing) channel
//     drop_cnt   - packed saturating per-channel drop counters, channel i at
//                  [i*CW +: CW]; only present with PULSE_SCHED_DROP_CNT_EN
//
//   Build option: define PULSE_SCHED_DROP_CNT_EN to add the CW parameter,
//   the drop counters and the drop_cnt port.
module pulse_req_scheduler #(
  parameter int N  = 4
`ifdef PULSE_SCHED_DROP_CNT_EN
  ,
  parameter int CW = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_in,
  pulse_req_scheduler_if.master svc,
  output logic [N-1:0]         pend_out,
  output logic                 busy,
  output logic [N-1:0]         drop_pulse
`ifdef PULSE_SCHED_DROP_CNT_EN
  ,
  output logic [N*CW-1:0]      drop_cnt
`endif
);
  localparam int IDW = $clog2(N);

  // Two-bit encoding leaves spare codes; they fall back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1
  } state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   prev_req_reg;
  logic [N-1:0]   pend_reg, pend_next;
  logic [N-1:0]   drop_pulse_reg, drop_next;
  logic [N-1:0]   edge_det;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [IDW-1:0] id_reg, id_next;
  logic [IDW-1:0] sel_id, scan_id;
  logic           sel_found;
  logic           serving;
  logic           done;
  int             scan_idx;

  // Moore decode: only the state register drives the handshake outputs.
  always_comb begin
    serving = 1'b0;
    case (state_reg)
      SERVE:   serving = 1'b1;
      default: serving = 1'b0;
    endcase
  end

  assign done = serving & svc.svc_ready;

  // Per-channel edge detect, pending flag and drop detection.
  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic comp;

    // This channel's grant is being accepted this cycle.
    assign comp            = done & (id_reg == IDW'(gi));
    assign edge_det[gi]    = req_in[gi] & ~prev_req_reg[gi];
    // A new edge wins over completion: it re-arms the event rather than
    // counting as a drop.
    assign pend_next[gi]   = edge_det[gi] | (pend_reg[gi] & ~comp);
    assign drop_next[gi]   = edge_det[gi] & pend_reg[gi] & ~comp;
    assign svc.svc_onehot[gi] = serving & (id_reg == IDW'(gi));

`ifdef PULSE_SCHED_DROP_CNT_EN
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (drop_next[gi] && (cnt_reg != {CW{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign drop_cnt[gi*CW +: CW] = cnt_reg;
`endif
  end

  // Round-robin pick: first pending bit scanning ptr, ptr+1, ... wrapping.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    scan_idx  = 0;
    scan_id   = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = int'(ptr_reg) + k;
      if (scan_idx >= N) begin
        scan_idx = scan_idx - N;
      end
      scan_id = IDW'(scan_idx);
      if (!sel_found && pend_reg[scan_id]) begin
        sel_found = 1'b1;
        sel_id    = scan_id;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          id_next    = sel_id;
          state_next = SERVE;
        end
      end
      SERVE: begin
        if (svc.svc_ready) begin
          ptr_next   = (id_reg == IDW'(N - 1)) ? '0 : id_reg + 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      // All-ones so a line held high through reset produces no event.
      prev_req_reg   <= '1;
      pend_reg       <= '0;
      ptr_reg        <= '0;
      id_reg         <= '0;
      drop_pulse_reg <= '0;
    end else begin
      state_reg      <= state_next;
      prev_req_reg   <= req_in;
      pend_reg       <= pend_next;
      ptr_reg        <= ptr_next;
      id_reg         <= id_next;
      drop_pulse_reg <= drop_next;
    end
  end

  assign svc.svc_valid = serving;
  assign svc.svc_id    = id_reg;
  assign busy          = serving;
  assign pend_out      = pend_reg;
  assign drop_pulse    = drop_pulse_reg;

endmodule

// File: tb/tb_pulse_req_scheduler.sv
// tb_pulse_req_scheduler
//   Directed scenarios plus a randomized run checked against a cycle
//   reference model of the scheduling rules (N=4).
module tb_pulse_req_scheduler;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_in = '0;
  logic [N-1:0] pend_out;
  logic         busy;
  logic [N-1:0] drop_pulse;
`ifdef PULSE_SCHED_DROP_CNT_EN
  logic [N*CW-1:0] drop_cnt;
`endif

  pulse_req_scheduler_if #(.N(N)) svc ();

  pulse_req_scheduler #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .svc        (svc),
    .pend_out   (pend_out),
    .busy       (busy),
    .drop_pulse (drop_pulse)
`ifdef PULSE_SCHED_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [N-1:0] m_prev, m_pend, m_drop;
  int           m_ptr, m_id;
  bit           m_serve;
  int           m_cnt[N];

  function automatic void model_step(input logic r, input logic [N-1:0] rq, input logic rdy);
    logic [N-1:0] np, nd;
    bit done;
    if (r) begin
      m_prev = '1; m_pend = '0; m_drop = '0;
      m_ptr = 0; m_id = 0; m_serve = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    done = m_serve && rdy;
    for (int i = 0; i < N; i++) begin
      bit e, fin;
      e   = rq[i] && !m_prev[i];
      fin = done && (m_id == i);
      nd[i] = e && m_pend[i] && !fin;
      np[i] = e || (m_pend[i] && !fin);
      if (nd[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
    end
    if (!m_serve) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_pend[c]) begin
          m_id = c;
          m_serve = 1;
          break;
        end
      end
    end else if (rdy) begin
      m_ptr = (m_id + 1) % N;
      m_serve = 0;
    end
    m_prev = rq; m_pend = np; m_drop = nd;
  endfunction

  // One clock: drive on the falling edge, advance the model on the rising
  // edge, return 1 time unit later so outputs are settled for sampling.
  task automatic tick(input logic r, input logic [N-1:0] rq, input logic rdy);
    @(negedge clk);
    rst = r; req_in = rq; svc.svc_ready = rdy;
    @(posedge clk);
    model_step(r, rq, rdy);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 4'b1111, 1'b1);
    tick(1'b1, 4'b1111, 1'b1);
    n_cmp++;
    if (svc.svc_valid !== 1'b0 || busy !== 1'b0 || svc.svc_id !== 2'd0 ||
        svc.svc_onehot !== 4'b0000 || drop_pulse !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b busy=%b id=%0d onehot=%b drop=%b, want all 0",
               svc.svc_valid, busy, svc.svc_id, svc.svc_onehot, drop_pulse);
    end
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, 4'b1111, 1'b1);
      n_cmp++;
      if (pend_out !== 4'b0000 || svc.svc_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_held_high: cycle %0d got pend=%b valid=%b, want 0000/0", c, pend_out, svc.svc_valid);
      end
    end
`ifdef PULSE_SCHED_DROP_CNT_EN
    n_cmp++;
    if (drop_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_drop_cnt: got %h want 0", drop_cnt);
    end
`endif
    $display("test_reset done");
  endtask

  task automatic test_single();
    tick(1'b1, 4'b0000, 1'b1);
    tick(1'b0, 4'b0000, 1'b1);
    tick(1'b0, 4'b0100, 1'b1);  // E0
    n_cmp++;
    if (pend_out !== 4'b0100 || svc.svc_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_e0: got pend=%b valid=%b, want 0100/0", pend_out, svc.svc_valid);
    end
    tick(1'b0, 4'b0100, 1'b1);  // E1
    n_cmp++;
    if (svc.svc_valid !== 1'b1 || svc.svc_id !== 2'd2 || svc.svc_onehot !== 4'b0100 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_e1: got valid=%b id=%0d onehot=%b busy=%b, want 1/2/0100/1",
               svc.svc_valid, svc.svc_id, svc.svc_onehot, busy);
    end
    tick(1'b0, 4'b0100, 1'b1);  // E2: grant accepted
    n_cmp++;
    if (pend_out !== 4'b0000 || svc.svc_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_e2: got pend=%b valid=%b, want 0000/0", pend_out, svc.svc_valid);
    end
    // Pointer now 3: simultaneous edges on 0 and 3 must grant 3 first.
    tick(1'b0, 4'b1001, 1'b1);
    tick(1'b0, 4'b1001, 1'b1);
    n_cmp++;
    if (svc.svc_valid !== 1'b1 || svc.svc_id !== 2'd3) begin
      n_bad++;
      $display("FAIL single_ptr3: got valid=%b id=%0d, want 1/3", svc.svc_valid, svc.svc_id);
    end
    for (int c = 0; c < 4; c++) tick(1'b0, 4'b1001, 1'b1);
    $display("test_single done");
  endtask

  task automatic test_multi();
    int grants[$];
    bit prev_v;
    int back2back;
    tick(1'b1, 4'b0000, 1'b1);
    tick(1'b0, 4'b0000, 1'b1);
    tick(1'b0, 4'b1011, 1'b1);
    prev_v = 0; back2back = 0;
    for (int c = 0; c < 8; c++) begin
      tick(1'b0, 4'b1011, 1'b1);
      if (svc.svc_valid === 1'b1) begin
        grants.push_back(int'(svc.svc_id));
        if (prev_v) back2back++;
      end
      prev_v = (svc.svc_valid === 1'b1);
    end
    n_cmp++;
    if (grants.size() != 3) begin
      n_bad++;
      $display("FAIL multi_count: got %0d grants want 3", grants.size());
    end else begin
      n_cmp++;
      if (grants[0] != 0 || grants[1] != 1 || grants[2] != 3) begin
        n_bad++;
        $display("FAIL multi_order: got %0d,%0d,%0d want 0,1,3", grants[0], grants[1], grants[2]);
      end
    end
    n_cmp++;
    if (back2back != 0) begin
      n_bad++;
      $display("FAIL multi_idle_gap: got %0d back-to-back valid cycles want 0", back2back);
    end
    $display("test_multi done: %0d grants", grants.size());
  endtask

  task automatic test_stall_drop();
    tick(1'b1, 4'b0000, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b0, 4'b0010, 1'b0);
    for (int c = 0; c < 5; c++) tick(1'b0, 4'b0010, 1'b0);
    n_cmp++;
    if (svc.svc_valid !== 1'b1 || svc.svc_id !== 2'd1) begin
      n_bad++;
      $display("FAIL stall_hold: got valid=%b id=%0d want 1/1", svc.svc_valid, svc.svc_id);
    end
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b0, 4'b0010, 1'b0);
    n_cmp++;
    if (drop_pulse !== 4'b0010 || svc.svc_id !== 2'd1 || svc.svc_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_drop: got drop=%b id=%0d valid=%b want 0010/1/1", drop_pulse, svc.svc_id, svc.svc_valid);
    end
`ifdef PULSE_SCHED_DROP_CNT_EN
    n_cmp++;
    if (drop_cnt[1*CW +: CW] !== 4'd1) begin
      n_bad++;
      $display("FAIL stall_drop_cnt: got %0d want 1", drop_cnt[1*CW +: CW]);
    end
`endif
    tick(1'b0, 4'b0010, 1'b0);
    n_cmp++;
    if (drop_pulse !== 4'b0000) begin
      n_bad++;
      $display("FAIL stall_drop_once: got drop=%b want 0000", drop_pulse);
    end
    tick(1'b0, 4'b0010, 1'b1);
    n_cmp++;
    if (pend_out !== 4'b0000 || svc.svc_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_merge: got pend=%b valid=%b want 0000/0", pend_out, svc.svc_valid);
    end
    $display("test_stall_drop done");
  endtask

  task automatic test_same_cycle();
    tick(1'b1, 4'b0000, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b0, 4'b0010, 1'b0);
    tick(1'b0, 4'b0010, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b0, 4'b0010, 1'b1);  // completion and new edge together
    n_cmp++;
    if (pend_out[1] !== 1'b1 || drop_pulse !== 4'b0000 || svc.svc_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL same_cycle: got pend=%b drop=%b valid=%b want x1x/0000/0", pend_out, drop_pulse, svc.svc_valid);
    end
    tick(1'b0, 4'b0010, 1'b1);
    n_cmp++;
    if (svc.svc_valid !== 1'b1 || svc.svc_id !== 2'd1) begin
      n_bad++;
      $display("FAIL same_cycle_regrant: got valid=%b id=%0d want 1/1", svc.svc_valid, svc.svc_id);
    end
    tick(1'b0, 4'b0010, 1'b1);
    $display("test_same_cycle done");
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 4'b0000, 1'b1);
    tick(1'b0, 4'b0000, 1'b1);
    tick(1'b0, 4'b0100, 1'b1);
    tick(1'b0, 4'b0100, 1'b1);  // serving 2
    tick(1'b0, 4'b1100, 1'b1);  // 2 done, ptr=3, ch3 pending
    tick(1'b0, 4'b1100, 1'b0);
    n_cmp++;
    if (svc.svc_valid !== 1'b1 || svc.svc_id !== 2'd3) begin
      n_bad++;
      $display("FAIL mid_setup: got valid=%b id=%0d want 1/3", svc.svc_valid, svc.svc_id);
    end
    tick(1'b1, 4'b1100, 1'b0);
    n_cmp++;
    if (svc.svc_valid !== 1'b0 || pend_out !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got valid=%b pend=%b busy=%b want 0/0000/0", svc.svc_valid, pend_out, busy);
    end
    tick(1'b0, 4'b0000, 1'b0);
    tick(1'b0, 4'b1001, 1'b0);
    tick(1'b0, 4'b1001, 1'b0);
    n_cmp++;
    if (svc.svc_valid !== 1'b1 || svc.svc_id !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_ptr0: got valid=%b id=%0d want 1/0", svc.svc_valid, svc.svc_id);
    end
    // Ch0 stalled, ch3 pending: 20 more edges on ch3 are all drops.
    for (int d = 0; d < 20; d++) begin
      tick(1'b0, 4'b0001, 1'b0);
      tick(1'b0, 4'b1001, 1'b0);
      n_cmp++;
      if (drop_pulse !== 4'b1000) begin
        n_bad++;
        $display("FAIL mid_drop%0d: got drop=%b want 1000", d, drop_pulse);
      end
    end
`ifdef PULSE_SCHED_DROP_CNT_EN
    n_cmp++;
    if (drop_cnt[3*CW +: CW] !== 4'd15) begin
      n_bad++;
      $display("FAIL drop_cnt_sat: got %0d want 15", drop_cnt[3*CW +: CW]);
    end
`endif
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [N-1:0] rq, exp_oh;
    logic rdy, r;
    tick(1'b1, 4'b0000, 1'b1);
    for (int c = 0; c < 600; c++) begin
      rq  = N'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 99) == 0);
      tick(r, rq, rdy);
      exp_oh = m_serve ? (4'b0001 << m_id) : 4'b0000;
      n_cmp++;
      if (svc.svc_valid !== m_serve || busy !== m_serve) begin
        n_bad++;
        $display("FAIL rnd_valid c%0d: got valid=%b busy=%b want %b", c, svc.svc_valid, busy, m_serve);
      end
      n_cmp++;
      if (svc.svc_onehot !== exp_oh) begin
        n_bad++;
        $display("FAIL rnd_onehot c%0d: got %b want %b", c, svc.svc_onehot, exp_oh);
      end
      if (m_serve) begin
        n_cmp++;
        if (svc.svc_id !== IDW'(m_id)) begin
          n_bad++;
          $display("FAIL rnd_id c%0d: got %0d want %0d", c, svc.svc_id, m_id);
        end
      end
      n_cmp++;
      if (pend_out !== m_pend) begin
        n_bad++;
        $display("FAIL rnd_pend c%0d: got %b want %b", c, pend_out, m_pend);
      end
      n_cmp++;
      if (drop_pulse !== m_drop) begin
        n_bad++;
        $display("FAIL rnd_drop c%0d: got %b want %b", c, drop_pulse, m_drop);
      end
`ifdef PULSE_SCHED_DROP_CNT_EN
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (drop_cnt[i*CW +: CW] !== CW'(m_cnt[i])) begin
          n_bad++;
          $display("FAIL rnd_cnt c%0d ch%0d: got %0d want %0d", c, i, drop_cnt[i*CW +: CW], m_cnt[i]);
        end
      end
`endif
    end
    $display("test_random done");
  endtask

  initial begin
    svc.svc_ready = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_stall_drop();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_req_scheduler.md
Name: pulse_req_scheduler

Overview:
Multi-channel event scheduler for a single shared service resource. Each of N request lines is rising-edge detected in the same Moore style as the team's pulse FSMs, and each edge becomes a sticky pending event. A round-robin arbiter serves pending events one at a time through a valid/ready handshake. It sits between asynchronous-looking level requesters (already synchronised to clk) and one shared consumer.

Parameters:
N, 4, number of request channels; legal range 2..16.
IDW, $clog2(N), width of svc_id; derived, not overridden.
CW, 4, width of each per-channel drop counter (optional feature only).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
req_in  in  N  level request lines, synchronous to clk
svc_valid  out  1  grant valid to shared resource
svc_ready  in  1  resource accepts current grant
svc_id  out  IDW  index of granted channel; stable while svc_valid=1
svc_onehot  out  N  one-hot of svc_id when svc_valid=1, else 0
pend_out  out  N  current pending-event vector
busy  out  1  1 while in SERVE
drop_pulse  out  N  one-cycle flag: an edge arrived on an already-pending channel
drop_cnt  out  N*CW  packed per-channel drop counters, channel i at [i*CW +: CW] (EN only)

Behaviour:
- Reset (rst=1 at a clk edge): prev_req <= all 1s; pend <= 0; ptr <= 0; state <= IDLE; svc_valid=0, svc_id=0, svc_onehot=0, busy=0, drop_pulse=0, drop_cnt=0. Reset mid-SERVE abandons the grant with no completion.
- prev_req all-1s reset: a line held high through reset generates no event. A 0 must be sampled first, then a 1.
- edge[i] = req_in[i] & ~prev_req[i]; prev_req <= req_in every cycle.
- Completion: done = svc_valid & svc_ready.
- pend[i] next value, in priority order:
  - edge[i] -> 1.
  - done & svc_id==i & ~edge[i] -> 0.
  - Otherwise hold.
  - An edge on the same cycle as that channel's completion leaves pend[i]=1 as a new event, not a drop.
- drop_pulse[i] is registered and high for one cycle after an edge where pend[i]=1 and that channel is not completing this cycle. The event is merged, not queued.
- FSM states: IDLE, SERVE.
  - IDLE: if |pend, select the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1. Register svc_id; go to SERVE. Else stay.
  - SERVE: svc_valid=1, busy=1, svc_id held. On svc_ready: ptr <= (svc_id==N-1) ? 0 : svc_id+1; go to IDLE. Otherwise stay indefinitely (no timeout).
- Latency: edge sampled at clock E0 -> pend=1 after E0 -> svc_valid=1 after E1.
- Minimum two cycles per grant; IDLE always lasts at least one cycle between grants.
- Outputs svc_valid, svc_onehot and busy are decoded from registered state only (Moore); no combinational path from svc_ready or req_in to any output.
- An unreachable state encoding decodes to IDLE with all outputs 0.

Optional Feature:
Macro PULSE_SCHED_DROP_CNT_EN.
- Defined: drop_cnt port exists. Counter i increments on each drop event of channel i (same condition as drop_pulse), saturates at 2^CW-1, and clears only on rst.
- Undefined: drop_cnt port and counters are absent; drop_pulse is unchanged.

Test Plan:
- Reset with req_in=4'b1111 held, then hold 10 cycles -> pend_out=0, svc_valid never asserts.
- req_in[2] 0->1 sampled at E0, svc_ready=1 -> svc_valid=1 after E1 with svc_id=2, svc_onehot=4'b0100; pend_out[2]=0 after E2; ptr=3.
- Edges on channels 0,1,3 together, svc_ready=1, ptr=0 -> grant order 0,1,3 on consecutive SERVE cycles, each separated by one IDLE cycle.
- Channel 1 in SERVE with svc_ready=0 for 5 cycles, then a second edge on ch1 -> drop_pulse[1] high one cycle; svc_id stays 1; with EN, drop_cnt[1]=1.
- Channel 1 re-edges on the exact cycle its completion occurs -> no drop_pulse, pend_out[1] stays 1, ch1 is granted again on the next IDLE.
- rst asserted during SERVE (svc_id=3) -> next cycle svc_valid=0, pend_out=0, ptr=0. With EN, 20 drops on one channel -> drop_cnt saturates at 15.
